// File: rtl/interrupt_sequencer_pkg.sv
// Shared types, vector constants and the level-to-mask helper for the interrupt sequencer.
// Nesting depth follows INT_SEQ_NEST_EN (defined: 3-deep stack, undefined: single context).
package interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_SAVE    = 3'd2,
        ST_VECTOR  = 3'd3,
        ST_RESTORE = 3'd4,
        ST_RESUME  = 3'd5
    } state_e;

    localparam logic [31:0] VEC_BASE   = 32'h0000_1000;
    localparam logic [31:0] VEC_STRIDE = 32'h0000_0010;

`ifdef INT_SEQ_NEST_EN
    localparam int MAXD = 3;
`else
    localparam int MAXD = 1;
`endif
    localparam logic [1:0] MAXD_D = 2'(MAXD);

    // Level 0 shifts by 3 and yields an empty mask.
    function automatic logic [2:0] onehot(input logic [1:0] l);
        return 3'b001 << (l - 2'd1);
    endfunction

endpackage

// File: rtl/interrupt_sequencer_int_ctx_stack.sv
// LIFO of saved interrupt contexts {level, EPC}, MAXD entries deep.
// Held as one shift vector with the top entry in the low bits.
module interrupt_sequencer_int_ctx_stack
    import interrupt_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [1:0]  push_lvl,
    input  logic [31:0] push_epc,
    output logic [1:0]  top_lvl,
    output logic [31:0] top_epc,
    output logic [1:0]  depth
);

    localparam int CW = 34;
    localparam int SW = MAXD * CW;

    logic [SW-1:0] stk_q, stk_d;
    logic [1:0]    depth_q, depth_d;

    always_comb begin
        stk_d   = stk_q;
        depth_d = depth_q;
        if (push) begin
            stk_d   = (stk_q << CW) | SW'({push_lvl, push_epc});
            depth_d = depth_q + 2'd1;
        end else if (pop) begin
            stk_d   = stk_q >> CW;
            depth_d = depth_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stk_q   <= '0;
            depth_q <= 2'd0;
        end else begin
            stk_q   <= stk_d;
            depth_q <= depth_d;
        end
    end

    assign {top_lvl, top_epc} = stk_q[CW-1:0];
    assign depth              = depth_q;

endmodule

// File: rtl/interrupt_sequencer.sv
// Sequences interrupt entry/return around the coprocessor; sole driver of its write strobes.
// INT_SEQ_NEST_EN enables nested handlers (IE re-enabled in VECTOR, EPC rewrite on RESUME).
//
// state   | meaning
// IDLE    | waiting for eret or an accepted interrupt request
// DRAIN   | stalled, waiting for pipe_idle
// SAVE    | write IRS/IE/EPC, push context
// VECTOR  | redirect fetch to the level's handler
// RESTORE | clear the level's IRS bit, pop context
// RESUME  | redirect fetch to the popped EPC, re-enable IE
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        int_req,
    input  logic [1:0]  ints,
    input  logic        eret,
    input  logic        pipe_idle,
    input  logic [31:0] pc_next,
    output logic        stall,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        irs_set_en,
    output logic        irs_clr_en,
    output logic [2:0]  irs_w_mask,
    output logic        ie_w_en,
    output logic        ie_w_data,
    output logic        epc_w_en,
    output logic [31:0] epc_w_data,
    output logic [1:0]  depth,
    output logic        eret_err
);

    state_e      state_q, state_d;
    logic [1:0]  lvl_q, lvl_d;
    logic [31:0] pc_save_q, pc_save_d;
    logic        eret_err_q, eret_err_d;

    logic [1:0]  top_lvl;
    logic [31:0] top_epc;
    logic [1:0]  depth_w;

    logic        stall_s, flush_s, redirect_s, irs_set_s, irs_clr_s;
    logic        ie_en_s, ie_data_s, epc_en_s;
    logic [2:0]  mask_s;
    logic [31:0] rpc_s, epc_data_s;

    interrupt_sequencer_int_ctx_stack u_stack (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (en && (state_q == ST_SAVE)),
        .pop      (en && (state_q == ST_RESTORE)),
        .push_lvl (lvl_q),
        .push_epc (pc_save_q),
        .top_lvl  (top_lvl),
        .top_epc  (top_epc),
        .depth    (depth_w)
    );

    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        pc_save_d  = pc_save_q;
        eret_err_d = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (eret) begin
                        if (depth_w != 2'd0) state_d = ST_RESTORE;
                        else                 eret_err_d = 1'b1;
                    end else if (int_req && (ints != 2'd0) && (depth_w < MAXD_D)) begin
                        state_d   = ST_DRAIN;
                        lvl_d     = ints;
                        pc_save_d = pc_next;
                    end
                end
                ST_DRAIN:   if (pipe_idle) state_d = ST_SAVE;
                ST_SAVE:    state_d = ST_VECTOR;
                ST_VECTOR:  state_d = ST_IDLE;
                // Keep the popped context so RESUME can redirect after the stack moves.
                ST_RESTORE: begin
                    state_d   = ST_RESUME;
                    lvl_d     = top_lvl;
                    pc_save_d = top_epc;
                end
                ST_RESUME:  state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lvl_q      <= 2'd0;
            pc_save_q  <= 32'd0;
            eret_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lvl_q      <= lvl_d;
            pc_save_q  <= pc_save_d;
            eret_err_q <= eret_err_d;
        end
    end

    always_comb begin
        stall_s    = 1'b0;
        flush_s    = 1'b0;
        redirect_s = 1'b0;
        rpc_s      = 32'd0;
        irs_set_s  = 1'b0;
        irs_clr_s  = 1'b0;
        mask_s     = 3'b000;
        ie_en_s    = 1'b0;
        ie_data_s  = 1'b0;
        epc_en_s   = 1'b0;
        epc_data_s = 32'd0;
        case (state_q)
            ST_DRAIN: stall_s = 1'b1;
            ST_SAVE: begin
                stall_s    = 1'b1;
                irs_set_s  = 1'b1;
                mask_s     = onehot(lvl_q);
                ie_en_s    = 1'b1;
                epc_en_s   = 1'b1;
                epc_data_s = pc_save_q;
            end
            ST_VECTOR: begin
                redirect_s = 1'b1;
                flush_s    = 1'b1;
                rpc_s      = VEC_BASE + (32'(lvl_q) * VEC_STRIDE);
`ifdef INT_SEQ_NEST_EN
                ie_en_s    = 1'b1;
                ie_data_s  = 1'b1;
`endif
            end
            ST_RESTORE: begin
                stall_s   = 1'b1;
                irs_clr_s = 1'b1;
                mask_s    = ~onehot(top_lvl);
            end
            ST_RESUME: begin
                redirect_s = 1'b1;
                flush_s    = 1'b1;
                rpc_s      = pc_save_q;
                ie_en_s    = 1'b1;
                ie_data_s  = 1'b1;
`ifdef INT_SEQ_NEST_EN
                // Outer handler's EPC goes back into the coprocessor for its own ERET.
                if (depth_w != 2'd0) begin
                    epc_en_s   = 1'b1;
                    epc_data_s = top_epc;
                end
`endif
            end
            default: ;
        endcase
    end

    assign stall       = stall_s;
    assign flush       = en & flush_s;
    assign redirect    = en & redirect_s;
    assign redirect_pc = en ? rpc_s : 32'd0;
    assign irs_set_en  = en & irs_set_s;
    assign irs_clr_en  = en & irs_clr_s;
    assign irs_w_mask  = en ? mask_s : 3'b000;
    assign ie_w_en     = en & ie_en_s;
    assign ie_w_data   = en & ie_data_s;
    assign epc_w_en    = en & epc_en_s;
    assign epc_w_data  = en ? epc_data_s : 32'd0;
    assign depth       = en ? depth_w : 2'd0;
    assign eret_err    = en & eret_err_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Self-checking bench for interrupt_sequencer: scenario tasks plus randomized entry/return
// traffic checked against a queue-based context model.
module tb_interrupt_sequencer;

`ifdef INT_SEQ_NEST_EN
    localparam int MAXD = 3;
`else
    localparam int MAXD = 1;
`endif

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        redirect;
        logic [31:0] redirect_pc;
        logic        irs_set_en;
        logic        irs_clr_en;
        logic [2:0]  irs_w_mask;
        logic        ie_w_en;
        logic        ie_w_data;
        logic        epc_w_en;
        logic [31:0] epc_w_data;
        logic [1:0]  depth;
        logic        eret_err;
    } out_t;

    typedef struct {
        logic [1:0]  lvl;
        logic [31:0] epc;
    } ctx_t;

    logic        clk, rst_n, en, int_req, eret, pipe_idle;
    logic [1:0]  ints;
    logic [31:0] pc_next;
    logic        stall, flush, redirect, irs_set_en, irs_clr_en, ie_w_en, ie_w_data, epc_w_en, eret_err;
    logic [31:0] redirect_pc, epc_w_data;
    logic [2:0]  irs_w_mask;
    logic [1:0]  depth;
    out_t        obs;

    int   checks = 0;
    int   errors = 0;
    ctx_t stk[$];

    interrupt_sequencer dut (
        .clk(clk), .rst_n(rst_n), .en(en), .int_req(int_req), .ints(ints), .eret(eret),
        .pipe_idle(pipe_idle), .pc_next(pc_next), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .irs_set_en(irs_set_en),
        .irs_clr_en(irs_clr_en), .irs_w_mask(irs_w_mask), .ie_w_en(ie_w_en),
        .ie_w_data(ie_w_data), .epc_w_en(epc_w_en), .epc_w_data(epc_w_data),
        .depth(depth), .eret_err(eret_err)
    );

    assign obs = {stall, flush, redirect, redirect_pc, irs_set_en, irs_clr_en, irs_w_mask,
                  ie_w_en, ie_w_data, epc_w_en, epc_w_data, depth, eret_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] lvl_mask(input int l);
        return 3'(1 << (l - 1));
    endfunction

    // Full interrupt entry: request, k cycles of busy pipeline, save, vector, back to idle.
    task automatic do_entry(input int l, input logic [31:0] p, input int k, input string tag);
        out_t exp;
        int_req = 1'b1; ints = 2'(l); pc_next = p; pipe_idle = (k == 0);
        @(posedge clk); #1;
        int_req = 1'b0; ints = 2'($urandom_range(0, 3)); pc_next = $urandom;
        for (int i = 0; i <= k; i++) begin
            exp = '0; exp.stall = 1'b1; exp.depth = 2'(stk.size());
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s drain%0d: got %h expected %h", tag, i, obs, exp); end
            pipe_idle = (i == k);
            @(posedge clk); #1;
        end
        exp = '0; exp.stall = 1'b1; exp.irs_set_en = 1'b1; exp.irs_w_mask = lvl_mask(l);
        exp.ie_w_en = 1'b1; exp.epc_w_en = 1'b1; exp.epc_w_data = p; exp.depth = 2'(stk.size());
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s save: got %h expected %h", tag, obs, exp); end
        stk.push_back('{lvl: 2'(l), epc: p});
        @(posedge clk); #1;
        exp = '0; exp.redirect = 1'b1; exp.flush = 1'b1;
        exp.redirect_pc = 32'h0000_1000 + 32'(l) * 32'h0000_0010; exp.depth = 2'(stk.size());
`ifdef INT_SEQ_NEST_EN
        exp.ie_w_en = 1'b1; exp.ie_w_data = 1'b1;
`endif
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s vector: got %h expected %h", tag, obs, exp); end
        @(posedge clk); #1;
        exp = '0; exp.depth = 2'(stk.size());
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL %s idle: got %h expected %h", tag, obs, exp); end
    endtask

    // ERET: error pulse at depth 0, otherwise restore/resume against the model stack.
    task automatic do_eret(input string tag);
        out_t exp;
        ctx_t c;
        eret = 1'b1;
        @(posedge clk); #1;
        eret = 1'b0;
        if (stk.size() == 0) begin
            exp = '0; exp.eret_err = 1'b1;
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s err_pulse: got %h expected %h", tag, obs, exp); end
            @(posedge clk); #1;
            exp = '0;
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s err_clear: got %h expected %h", tag, obs, exp); end
        end else begin
            c = stk.pop_back();
            exp = '0; exp.stall = 1'b1; exp.irs_clr_en = 1'b1; exp.irs_w_mask = ~lvl_mask(int'(c.lvl));
            exp.depth = 2'(stk.size() + 1);
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s restore: got %h expected %h", tag, obs, exp); end
            @(posedge clk); #1;
            exp = '0; exp.redirect = 1'b1; exp.flush = 1'b1; exp.redirect_pc = c.epc;
            exp.ie_w_en = 1'b1; exp.ie_w_data = 1'b1; exp.depth = 2'(stk.size());
`ifdef INT_SEQ_NEST_EN
            if (stk.size() > 0) begin exp.epc_w_en = 1'b1; exp.epc_w_data = stk[$].epc; end
`endif
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s resume: got %h expected %h", tag, obs, exp); end
            @(posedge clk); #1;
            exp = '0; exp.depth = 2'(stk.size());
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s idle: got %h expected %h", tag, obs, exp); end
        end
    endtask

    // Request at full depth must be ignored.
    task automatic do_ignore(input string tag);
        out_t exp;
        int_req = 1'b1; ints = 2'($urandom_range(1, 3)); pc_next = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp = '0; exp.depth = 2'(stk.size());
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL %s cyc%0d: got %h expected %h", tag, i, obs, exp); end
        end
        int_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; int_req = 1'b1; ints = 2'd2; eret = 1'b0; pipe_idle = 1'b1; pc_next = 32'h1234;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset: got %h expected 0", obs); end
        int_req = 1'b0; ints = 2'd0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_release: got %h expected 0", obs); end
    endtask

    task automatic test_entry();
        do_entry(2, 32'h0000_0400, 0, "entry_l2");
    endtask

    task automatic test_return();
        do_eret("return_d1");
    endtask

    task automatic test_eret_err();
        do_eret("eret_d0");
    endtask

    task automatic test_drain_hold();
        do_entry(3, $urandom, 4, "drain_hold");
    endtask

    task automatic test_same_cycle();
        int l;
        l = $urandom_range(1, 3);
        int_req = 1'b1; ints = 2'(l);
        do_eret("same_cycle_ret");
        do_entry(l, $urandom, 0, "same_cycle_int");
    endtask

    task automatic test_depth_limit();
        while (stk.size() > 0) do_eret("drain_stack");
`ifdef INT_SEQ_NEST_EN
        do_entry(1, 32'h0000_0200, 0, "nest_l1");
        do_entry(3, $urandom, 0, "nest_l3");
        do_eret("nest_ret_l3");
        do_eret("nest_ret_l1");
`else
        do_entry($urandom_range(1, 3), $urandom, 0, "single_entry");
        do_ignore("ignore_d1");
        do_eret("single_ret");
`endif
    endtask

    task automatic test_enable();
        out_t exp;
        logic [31:0] p;
        p = $urandom;
        int_req = 1'b1; ints = 2'd1; pc_next = p; pipe_idle = 1'b1;
        @(posedge clk); #1;
        int_req = 1'b0; en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = '0; exp.stall = 1'b1;
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL en_low cyc%0d: got %h expected %h", i, obs, exp); end
            @(posedge clk); #1;
        end
        en = 1'b1; #1;
        exp = '0; exp.stall = 1'b1; exp.depth = 2'(stk.size());
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL en_resume_drain: got %h expected %h", obs, exp); end
        @(posedge clk); #1;
        exp = '0; exp.stall = 1'b1; exp.irs_set_en = 1'b1; exp.irs_w_mask = 3'b001;
        exp.ie_w_en = 1'b1; exp.epc_w_en = 1'b1; exp.epc_w_data = p; exp.depth = 2'(stk.size());
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL en_resume_save: got %h expected %h", obs, exp); end
        stk.push_back('{lvl: 2'd1, epc: p});
        repeat (2) @(posedge clk);
        #1;
        exp = '0; exp.depth = 2'(stk.size());
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL en_resume_idle: got %h expected %h", obs, exp); end
        while (stk.size() > 0) do_eret("en_cleanup");
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) < 2) begin
                if (stk.size() < MAXD) do_entry($urandom_range(1, 3), $urandom, $urandom_range(0, 3), "rand_entry");
                else                   do_ignore("rand_ignore");
            end else begin
                do_eret("rand_eret");
            end
        end
        while (stk.size() > 0) do_eret("rand_cleanup");
    endtask

    task automatic test_reset_mid_save();
        int_req = 1'b1; ints = 2'd2; pc_next = $urandom; pipe_idle = 1'b1;
        @(posedge clk); #1;
        int_req = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (irs_set_en !== 1'b1) begin errors++; $display("FAIL reach_save: got irs_set_en=%b expected 1", irs_set_en); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL reset_mid_save: got %h expected 0", obs); end
        stk.delete();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (obs !== '0) begin errors++; $display("FAIL after_reset_idle: got %h expected 0", obs); end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_return();
        test_eret_err();
        test_drain_hold();
        test_same_cycle();
        test_depth_limit();
        test_enable();
        test_random();
        test_reset_mid_save();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
